// File: rtl/ad7606c18_pkg.sv
// Shared types and constants for the AD7606C-18 parallel-interface emulator.
// Holds the conversion state encoding, bus geometry and word formatting.
package ad7606c18_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_CONV  = 2'd2
    } state_t;

    localparam int WORDS  = 16;
    localparam int N_CH   = 8;
    localparam int CH_W   = 18;
    localparam int BUS_W  = 16;
    localparam int PTR_W  = 4;
    localparam int BANK_W = N_CH * CH_W;

    // Second word carries the two LSBs swapped, matching the host's unpacking.
    function automatic logic [BUS_W-1:0] bus_word(input logic [CH_W-1:0] sample,
                                                  input logic second);
        if (second)
            return {{(BUS_W-2){1'b0}}, sample[0], sample[1]};
        return sample[CH_W-1:2];
    endfunction

endpackage

// File: rtl/ad7606c18_rd_port.sv
// Parallel read port: registers CS/RD, advances the word pointer at each read end
// and presents the selected result word with FRSTDATA and the bus enable.
module ad7606c18_rd_port
    import ad7606c18_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_reset,
    input  logic              ad_cs,
    input  logic              ad_rd,
    input  logic              ptr_clr,
    input  logic [BANK_W-1:0] bank,
    output logic [BUS_W-1:0]  ad_data,
    output logic              ad_data_oe,
    output logic              first_data
);

    logic             cs_reg;
    logic             rd_reg;
    logic             active_prev_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [BUS_W-1:0] data_reg;
    logic             oe_reg;
    logic             first_reg;

    logic [CH_W-1:0]  samples [N_CH];
    logic [CH_W-1:0]  cur_sample;
    logic             active;
    logic             read_end;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_slice
            assign samples[gi] = bank[gi*CH_W +: CH_W];
        end
    endgenerate

    assign active     = ~cs_reg & ~rd_reg;
    assign read_end   = active_prev_reg & ~active;
    assign cur_sample = samples[ptr_reg[PTR_W-1:1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_reg          <= 1'b1;
            rd_reg          <= 1'b1;
            active_prev_reg <= 1'b0;
            ptr_reg         <= '0;
            data_reg        <= '0;
            oe_reg          <= 1'b0;
            first_reg       <= 1'b0;
        end else if (ad_reset) begin
            cs_reg          <= 1'b1;
            rd_reg          <= 1'b1;
            active_prev_reg <= 1'b0;
            ptr_reg         <= '0;
            data_reg        <= '0;
            oe_reg          <= 1'b0;
            first_reg       <= 1'b0;
        end else begin
            cs_reg          <= ad_cs;
            rd_reg          <= ad_rd;
            active_prev_reg <= active;
            // A conversion end takes priority over a coincident read end.
            if (ptr_clr)
                ptr_reg <= '0;
            else if (read_end)
                ptr_reg <= ptr_reg + 1'b1;
            data_reg  <= active ? bus_word(cur_sample, ptr_reg[0]) : '0;
            oe_reg    <= active;
            first_reg <= active && (ptr_reg[PTR_W-1:1] == '0);
        end
    end

    assign ad_data    = data_reg;
    assign ad_data_oe = oe_reg;
    assign first_data = first_reg;

endmodule

// File: rtl/ad7606c18_emu.sv
// Device-side AD7606C-18 emulator: CONVST-driven conversion timing, source
// snapshot and result banks, test-pattern counter, and the parallel read port.
module ad7606c18_emu
    import ad7606c18_pkg::*;
#(
    parameter int CONV_CYCLES = 50,
    parameter int BUSY_DLY    = 1,
    parameter int NCH         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_reset,
    input  logic              ad_convstab,
    input  logic              ad_cs,
    input  logic              ad_rd,
    input  logic [2:0]        ad_os,
    input  logic              pattern_en,
    input  logic [BANK_W-1:0] ch_data,
    output logic [BUS_W-1:0]  ad_data,
    output logic              ad_data_oe,
    output logic              ad_busy,
    output logic              first_data
);

    state_t            state_reg, state_next;
    logic              convst_reg, convst_prev_reg;
    logic [15:0]       cnt_reg, cnt_next;
    logic [2:0]        os_reg, os_next;
    logic              busy_reg, busy_next;
    logic [14:0]       pat_reg, pat_next;
    logic [BANK_W-1:0] snap_reg, snap_next;
    logic [BANK_W-1:0] result_reg, result_next;
    logic [BANK_W-1:0] pat_bank;
    logic              convst_rise;
    logic              ptr_clr;
    logic [15:0]       conv_len;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_pat
            assign pat_bank[gi*CH_W +: CH_W] = {pat_reg, 3'(gi)};
        end
    endgenerate

    assign convst_rise = convst_reg & ~convst_prev_reg;
    assign conv_len    = 16'(CONV_CYCLES) << os_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        os_next     = os_reg;
        busy_next   = busy_reg;
        pat_next    = pat_reg;
        snap_next   = snap_reg;
        result_next = result_reg;
        ptr_clr     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (convst_rise) begin
                    state_next = ST_DELAY;
                    cnt_next   = '0;
                    os_next    = (ad_os == 3'd7) ? 3'd0 : ad_os;
                    snap_next  = pattern_en ? pat_bank : ch_data;
                end
            end
            ST_DELAY: begin
                if (cnt_reg == 16'(BUSY_DLY - 1)) begin
                    state_next = ST_CONV;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_CONV: begin
                if (cnt_reg == conv_len - 16'd1) begin
                    state_next  = ST_IDLE;
                    cnt_next    = '0;
                    busy_next   = 1'b0;
                    result_next = snap_reg;
                    pat_next    = pat_reg + 15'd1;
                    ptr_clr     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            convst_reg      <= 1'b0;
            convst_prev_reg <= 1'b0;
            cnt_reg         <= '0;
            os_reg          <= '0;
            busy_reg        <= 1'b0;
            pat_reg         <= '0;
            snap_reg        <= '0;
            result_reg      <= '0;
        end else if (ad_reset) begin
            state_reg       <= ST_IDLE;
            convst_reg      <= 1'b0;
            convst_prev_reg <= 1'b0;
            cnt_reg         <= '0;
            os_reg          <= '0;
            busy_reg        <= 1'b0;
            pat_reg         <= '0;
            snap_reg        <= '0;
            result_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            convst_reg      <= ad_convstab;
            convst_prev_reg <= convst_reg;
            cnt_reg         <= cnt_next;
            os_reg          <= os_next;
            busy_reg        <= busy_next;
            pat_reg         <= pat_next;
            snap_reg        <= snap_next;
            result_reg      <= result_next;
        end
    end

    assign ad_busy = busy_reg;

    ad7606c18_rd_port u_rd_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .ad_reset   (ad_reset),
        .ad_cs      (ad_cs),
        .ad_rd      (ad_rd),
        .ptr_clr    (ptr_clr),
        .bank       (result_reg),
        .ad_data    (ad_data),
        .ad_data_oe (ad_data_oe),
        .first_data (first_data)
    );

endmodule

// File: tb/tb_ad7606c18_emu.sv
// Randomized bench for the AD7606C-18 emulator against a behavioural model of
// the result bank, word pointer and pattern counter.
module tb_ad7606c18_emu;

    localparam int CONV_CYCLES = 50;
    localparam int BUSY_DLY    = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ad_reset = 1'b0;
    logic         ad_convstab = 1'b0;
    logic         ad_cs = 1'b1;
    logic         ad_rd = 1'b1;
    logic [2:0]   ad_os = 3'd0;
    logic         pattern_en = 1'b0;
    logic [143:0] ch_data = '0;
    logic [15:0]  ad_data;
    logic         ad_data_oe;
    logic         ad_busy;
    logic         first_data;

    int n_vec = 0;
    int n_bad = 0;
    int bank_m[8];
    int ptr_m = 0;
    int pat_m = 0;

    always #10 clk = ~clk;

    ad7606c18_emu #(
        .CONV_CYCLES (CONV_CYCLES),
        .BUSY_DLY    (BUSY_DLY),
        .NCH         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ad_reset    (ad_reset),
        .ad_convstab (ad_convstab),
        .ad_cs       (ad_cs),
        .ad_rd       (ad_rd),
        .ad_os       (ad_os),
        .pattern_en  (pattern_en),
        .ch_data     (ch_data),
        .ad_data     (ad_data),
        .ad_data_oe  (ad_data_oe),
        .ad_busy     (ad_busy),
        .first_data  (first_data)
    );

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word k of the bank: even = code / 4, odd = {code bit0, code bit1}.
    function automatic int model_word(input int k);
        int code = bank_m[k / 2];
        if (k % 2 == 0)
            return code / 4;
        return (code % 2) * 2 + (code / 2) % 2;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 8; n++) bank_m[n] = 0;
        ptr_m = 0;
        pat_m = 0;
    endtask

    task automatic do_read(input string tag, input bit cs_only);
        ad_cs = 1'b0;
        ad_rd = 1'b0;
        tick();
        tick();
        check_vec({tag, "_data"}, int'(ad_data), model_word(ptr_m));
        check_vec({tag, "_oe"}, int'(ad_data_oe), 1);
        check_vec({tag, "_first"}, int'(first_data), (ptr_m < 2) ? 1 : 0);
        ad_cs = 1'b1;
        if (!cs_only) ad_rd = 1'b1;
        tick();
        check_vec({tag, "_oe_hold"}, int'(ad_data_oe), 1);
        tick();
        check_vec({tag, "_oe_off"}, int'(ad_data_oe), 0);
        ad_rd = 1'b1;
        ptr_m = (ptr_m + 1) % 16;
        $display("read %s word %0d data 0x%04h first %0d", tag, (ptr_m + 15) % 16,
                 ad_data, first_data);
    endtask

    task automatic read_n(input string tag, input int n);
        for (int i = 0; i < n; i++) do_read(tag, (i % 3) == 2);
    endtask

    task automatic convert(input int os_sel, input bit pat, input logic [143:0] data,
                           input bit mid_reads, input bit mid_convst);
        int snap[8];
        int lat;
        int dur;
        int eff_os;
        ad_os      = 3'(os_sel);
        pattern_en = pat;
        ch_data    = data;
        for (int n = 0; n < 8; n++)
            snap[n] = pat ? (pat_m * 8 + n) : int'(data[18*n +: 18]);
        ad_convstab = 1'b1;
        tick();
        ad_convstab = 1'b0;
        lat = 1;
        while (ad_busy !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        // Two input register stages, then BUSY_DLY cycles before BUSY.
        check_vec("busy_latency", lat, BUSY_DLY + 2);
        dur = 0;
        fork
            begin
                while (ad_busy === 1'b1 && dur < 5000) begin
                    tick();
                    dur++;
                end
            end
            begin
                if (mid_reads) read_n("rd_busy", 3);
                if (mid_convst) begin
                    for (int i = 0; i < 5; i++) tick();
                    ad_convstab = 1'b1;
                    tick();
                    ad_convstab = 1'b0;
                end
            end
        join
        eff_os = (os_sel == 7) ? 0 : os_sel;
        check_vec("busy_len", dur, CONV_CYCLES * (1 << eff_os));
        for (int n = 0; n < 8; n++) bank_m[n] = snap[n];
        pat_m = (pat_m + 1) % 32768;
        ptr_m = 0;
        $display("conv os %0d pat %0d busy_len %0d", os_sel, pat, dur);
    endtask

    function automatic logic [143:0] rand_data();
        logic [159:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return tmp[143:0];
    endfunction

    initial begin
        logic [143:0] data;
        int os_tab[4];
        os_tab[0] = 0; os_tab[1] = 1; os_tab[2] = 2; os_tab[3] = 7;
        model_reset();

        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check_vec("rst_busy", int'(ad_busy), 0);
        check_vec("rst_data", int'(ad_data), 0);
        check_vec("rst_oe", int'(ad_data_oe), 0);
        check_vec("rst_first", int'(first_data), 0);

        // Test-pattern conversions as the host sequences them.
        convert(0, 1'b1, '0, 1'b0, 1'b0);
        read_n("rd_pat0", 16);
        convert(0, 1'b1, '0, 1'b0, 1'b0);
        read_n("rd_pat1", 16);

        // External data with the corner codes.
        data = rand_data();
        data[17:0]    = 18'h2ABCD;
        data[143:126] = 18'h1FFFF;
        convert(0, 1'b0, data, 1'b0, 1'b0);
        read_n("rd_ext", 16);

        // Oversampling lengths.
        convert(3, 1'b1, '0, 1'b0, 1'b0);
        read_n("rd_os3", 4);
        convert(7, 1'b0, rand_data(), 1'b0, 1'b0);
        read_n("rd_os7", 4);

        // Reads and a CONVST while busy, then a wrapping burst.
        convert(0, 1'b0, rand_data(), 1'b1, 1'b1);
        read_n("rd_wrap", 17);

        for (int it = 0; it < 6; it++) begin
            convert(os_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), rand_data(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            read_n("rd_rand", $urandom_range(1, 18));
        end

        // Asynchronous reset in the middle of a conversion.
        data = rand_data();
        data[17:0] = 18'h3FFFC;
        convert(0, 1'b0, data, 1'b0, 1'b0);
        ad_convstab = 1'b1;
        tick();
        ad_convstab = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_vec("busy_mid", int'(ad_busy), 1);
        ad_cs = 1'b0;
        ad_rd = 1'b0;
        tick();
        tick();
        check_vec("rd_pre_rst", int'(ad_data), model_word(ptr_m));
        rst_n = 1'b0;
        #1;
        check_vec("arst_busy", int'(ad_busy), 0);
        check_vec("arst_data", int'(ad_data), 0);
        check_vec("arst_oe", int'(ad_data_oe), 0);
        ad_cs = 1'b1;
        ad_rd = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        read_n("rd_after_arst", 4);

        // Synchronous device reset held for 100 cycles.
        convert(1, 1'b0, rand_data(), 1'b0, 1'b0);
        ad_reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) ad_convstab = 1'b1;
            if (i == 11) ad_convstab = 1'b0;
            if (i == 20) begin
                ad_cs = 1'b0;
                ad_rd = 1'b0;
            end
            tick();
        end
        check_vec("srst_busy", int'(ad_busy), 0);
        check_vec("srst_data", int'(ad_data), 0);
        check_vec("srst_oe", int'(ad_data_oe), 0);
        ad_cs = 1'b1;
        ad_rd = 1'b1;
        ad_reset = 1'b0;
        model_reset();
        tick();
        tick();
        check_vec("srst_idle", int'(ad_busy), 0);
        convert(0, 1'b1, '0, 1'b0, 1'b0);
        read_n("rd_after_srst", 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
